// File: rtl/grf_trace.sv
// 32x32 register file with write-first bypass on both read ports and a
// first-word-fall-through trace FIFO that records every architectural write.
module grf_trace #(
  parameter int TRACE_DEPTH = 4,
  parameter int TRACE_AW    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4:0]          ra1,
  input  logic [4:0]          ra2,
  output logic [31:0]         rd1,
  output logic [31:0]         rd2,
  input  logic                we,
  input  logic [4:0]          wa,
  input  logic [31:0]         wd,
  input  logic [31:0]         wpc,
  output logic                trace_valid,
  input  logic                trace_ready,
  output logic [31:0]         trace_pc,
  output logic [4:0]          trace_addr,
  output logic [31:0]         trace_data,
  output logic [TRACE_AW:0]   trace_count,
  output logic                trace_overflow
);
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  addr;
    logic [31:0] data;
  } trace_ent_t;

  logic [31:0]         regs [32];
  trace_ent_t          fifo [TRACE_DEPTH];
  logic [TRACE_AW-1:0] wr_ptr, rd_ptr;
  logic [TRACE_AW:0]   count;
  logic                push, pop, full, accept;

  assign push   = we && (wa != 5'd0);
  assign full   = (count == (TRACE_AW+1)'(TRACE_DEPTH));
  assign pop    = trace_valid && trace_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign accept = push && (!full || pop);

  assign trace_valid = (count != '0);
  assign trace_count = count;
  assign trace_pc    = fifo[rd_ptr].pc;
  assign trace_addr  = fifo[rd_ptr].addr;
  assign trace_data  = fifo[rd_ptr].data;

  always_comb begin
    rd1 = regs[ra1];
    if (ra1 == 5'd0)             rd1 = '0;
    else if (we && (wa == ra1))  rd1 = wd;
  end

  always_comb begin
    rd2 = regs[ra2];
    if (ra2 == 5'd0)             rd2 = '0;
    else if (we && (wa == ra2))  rd2 = wd;
  end

  // regs[0] is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (push) begin
      regs[wa] <= wd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      trace_overflow <= 1'b0;
      for (int i = 0; i < TRACE_DEPTH; i++) fifo[i] <= '0;
    end else begin
      if (accept) begin
        fifo[wr_ptr] <= '{pc: wpc, addr: wa, data: wd};
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full && !pop) trace_overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_grf_trace.sv
// Randomized bench for grf_trace against a queue/array reference model.
module tb_grf_trace;
  localparam int DEPTH = 4;

  logic        clk, reset;
  logic [4:0]  ra1, ra2, wa;
  logic [31:0] rd1, rd2, wd, wpc;
  logic        we, trace_ready, trace_valid, trace_overflow;
  logic [31:0] trace_pc, trace_data;
  logic [4:0]  trace_addr;
  logic [2:0]  trace_count;

  grf_trace #(.TRACE_DEPTH(DEPTH), .TRACE_AW(2)) dut (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .we(we), .wa(wa), .wd(wd), .wpc(wpc),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_addr(trace_addr), .trace_data(trace_data),
    .trace_count(trace_count), .trace_overflow(trace_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  logic [31:0] m_regs [32];
  ent_t        m_q [$];
  logic        m_ovf;
  int          n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_q.delete();
    m_ovf = 1'b0;
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] ra);
    if (ra == 0) return '0;
    if (we && wa == ra) return wd;
    return m_regs[ra];
  endfunction

  task automatic check_all();
    chk("rd1", rd1, exp_rd(ra1));
    chk("rd2", rd2, exp_rd(ra2));
    chk("valid", 32'(trace_valid), 32'(m_q.size() != 0));
    chk("count", 32'(trace_count), 32'(m_q.size()));
    chk("overflow", 32'(trace_overflow), 32'(m_ovf));
    if (m_q.size() != 0) begin
      chk("head_pc", trace_pc, m_q[0].pc);
      chk("head_addr", 32'(trace_addr), 32'(m_q[0].addr));
      chk("head_data", trace_data, m_q[0].data);
    end
  endtask

  // Apply inputs, let them settle, check pre-edge state.
  task automatic set_in(input logic w, input logic [4:0] a, input logic [31:0] d,
                        input logic [31:0] pc, input logic [4:0] r1, input logic [4:0] r2,
                        input logic rdy);
    we = w; wa = a; wd = d; wpc = pc; ra1 = r1; ra2 = r2; trace_ready = rdy;
    #2;
    check_all();
  endtask

  // Clock edge; model follows the architectural rules using pre-edge state.
  task automatic step();
    bit push, pop, was_full;
    push     = we && (wa != 0);
    pop      = (m_q.size() != 0) && trace_ready;
    was_full = (m_q.size() == DEPTH);
    @(posedge clk);
    if (push) m_regs[wa] = wd;
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (!was_full || pop) m_q.push_back('{pc: wpc, addr: wa, data: wd});
      else m_ovf = 1'b1;
    end
    #1;
  endtask

  task automatic cyc(input logic w, input logic [4:0] a, input logic [31:0] d,
                     input logic [31:0] pc, input logic [4:0] r1, input logic [4:0] r2,
                     input logic rdy);
    set_in(w, a, d, pc, r1, r2, rdy);
    step();
  endtask

  initial begin
    we = 0; wa = 0; wd = 0; wpc = 0; ra1 = 0; ra2 = 0; trace_ready = 0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    set_in(0, 0, 0, 0, 5'd5, 5'd0, 0);
    chk("rst_pc", trace_pc, 0);
    chk("rst_addr", 32'(trace_addr), 0);
    chk("rst_data", trace_data, 0);
    step();

    // Bypass, then registered value
    set_in(1, 5'd8, 32'h1234_5678, 32'h0000_1000, 5'd8, 5'd8, 0);
    chk("bypass_rd1", rd1, 32'h1234_5678);
    step();
    set_in(0, 0, 0, 0, 5'd8, 5'd0, 0);
    chk("stored_rd1", rd1, 32'h1234_5678);
    chk("head_addr8", 32'(trace_addr), 8);
    step();

    // Write to $0 is ignored
    cyc(1, 5'd0, 32'hFFFF_FFFF, 32'h0000_1004, 5'd0, 5'd0, 0);
    set_in(0, 0, 0, 0, 5'd0, 5'd8, 0);
    chk("zero_rd1", rd1, 0);
    chk("zero_count", 32'(trace_count), 1);
    step();

    // Drain the $8 entry, then overflow sequence
    cyc(0, 0, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 5; i++)
      cyc(1, 5'(i), 32'(32'hA0 + i), 32'(32'h2000 + 4 * i), 5'(i), 5'd0, 0);
    set_in(0, 0, 0, 0, 5'd5, 5'd4, 0);
    chk("ovf_count", 32'(trace_count), 4);
    chk("ovf_flag", 32'(trace_overflow), 1);
    chk("reg5_written", rd1, 32'hA5);
    step();

    // Full with ready: push accepted alongside pop
    cyc(1, 5'd31, 32'h0000_3008, 32'h0000_3000, 5'd31, 0, 1);
    chk("full_pushpop_count", 32'(trace_count), 4);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 1);
    set_in(0, 0, 0, 0, 0, 0, 1);
    chk("drained", 32'(trace_valid), 0);
    step();
    cyc(0, 0, 0, 0, 0, 0, 1);  // empty FIFO ignores ready

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [4:0] a;
      a = (($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)));
      cyc(1'($urandom_range(0, 3) != 0), a, $urandom, $urandom,
          (($urandom_range(0, 2) == 0) ? a : 5'($urandom)),
          5'($urandom), 1'($urandom_range(0, 2) == 0));
    end

    // Async reset mid-drain with count=3 and overflow set
    for (int n = 0; n < 32; n++) cyc(0, 0, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 5; i++)
      cyc(1, 5'(i + 10), 32'(32'hC0 + i), 32'(32'h4000 + 4 * i), 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    set_in(0, 0, 0, 0, 5'd11, 5'd12, 1);
    chk("pre_rst_count", 32'(trace_count), 3);
    reset = 1'b1;
    #1;
    model_reset();
    chk("arst_valid", 32'(trace_valid), 0);
    chk("arst_count", 32'(trace_count), 0);
    chk("arst_ovf", 32'(trace_overflow), 0);
    chk("arst_rd1", rd1, 0);
    chk("arst_rd2", rd2, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    cyc(0, 0, 0, 0, 5'd13, 5'd5, 0);
    cyc(1, 5'd3, 32'hDEAD_BEEF, 32'h5000, 5'd3, 5'd3, 1);
    cyc(0, 0, 0, 0, 5'd3, 5'd3, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
